// File: rtl/shift_reg_piso_pkg.sv
// Shared constants and helpers for the PISO shift register.
// Default word width and counter-width helper.
package shift_reg_piso_pkg;

   localparam int unsigned PISO_SIZE = 8;

   // Counter width for a frame of n bits, at least one bit.
   function automatic int unsigned piso_cw(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_piso_frame_counter.sv
// Frame down-counter for the PISO shift register.
// Pulses load when the count is 0, then reloads to size-1.
module piso_frame_counter
   import shift_reg_piso_pkg::*;
#(
   parameter int unsigned size = PISO_SIZE
)
(
   input  logic clk,
   input  logic reset,
   output logic load
);

   localparam int unsigned CW = piso_cw(size);
   localparam logic [CW-1:0] LAST = CW'(size - 1);

   logic [CW-1:0] cnt;

   // Count down through the frame, wrapping only via the load path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= LAST;
      else
         cnt <= cnt - CW'(1);
   end

   // A zero count marks the last bit of a frame or the idle state after reset.
   always_comb begin
      load = (cnt == '0);
   end

endmodule

// File: rtl/shift_reg_piso.sv
// Parallel-in / serial-out shift register with automatic framing.
// Emits each captured word MSB first and recaptures with no idle gap.
module shift_reg_piso
   import shift_reg_piso_pkg::*;
#(
   parameter int unsigned size = PISO_SIZE
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] datain,
   output logic            dataout
);

   logic [size-1:0] sr;
   logic            load;

   piso_frame_counter #(
      .size (size)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (load)
   );

   // Capture a new word on load cycles, otherwise shift toward the MSB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sr <= '0;
      else if (load)
         sr <= datain;
      else
         sr <= {sr[size-2:0], 1'b0};
   end

   // Serial output is the register MSB with no extra flop.
   always_comb begin
      dataout = sr[size-1];
   end

endmodule

// File: tb/tb_shift_reg_piso.sv
// Self-checking bench for shift_reg_piso at widths 8 and 2.
// Outputs are compared against a queue-based frame model.
module tb_shift_reg_piso;

   logic       clk;
   logic       reset;
   logic [7:0] din8;
   logic [1:0] din2;
   logic       dout8;
   logic       dout2;

   int checks;
   int errors;

   bit q8[$];
   bit q2[$];
   bit exp8;
   bit exp2;

   shift_reg_piso #(
      .size (8)
   ) dut8 (
      .clk     (clk),
      .reset   (reset),
      .datain  (din8),
      .dataout (dout8)
   );

   shift_reg_piso #(
      .size (2)
   ) dut2 (
      .clk     (clk),
      .reset   (reset),
      .datain  (din2),
      .dataout (dout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Model: a frame is the word's bits, MSB first,
   // captured whenever the previous frame is used up.
   task automatic model_edge();
      if (q8.size() == 0)
         for (int i = 7; i >= 0; i--)
            q8.push_back(din8[i]);
      exp8 = q8.pop_front();
      if (q2.size() == 0)
         for (int i = 1; i >= 0; i--)
            q2.push_back(din2[i]);
      exp2 = q2.pop_front();
   endtask

   task automatic model_reset();
      q8.delete();
      q2.delete();
      exp8 = 1'b0;
      exp2 = 1'b0;
   endtask

   // Called with clk low; reset pulse lasts 2 time units.
   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, "_during8"}, 32'(dout8), 32'd0);
      chk({tag, "_during2"}, 32'(dout2), 32'd0);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      chk({tag, "_after8"}, 32'(dout8), 32'd0);
      chk({tag, "_after2"}, 32'(dout2), 32'd0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, "_8"}, 32'(dout8), 32'(exp8));
      chk({tag, "_2"}, 32'(dout2), 32'(exp2));
   endtask

   initial begin
      bit [7:0] pat;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      din8   = 8'h00;
      din2   = 2'b10;
      model_reset();

      // Reset values before any edge.
      pulse_reset("rst");

      // Alternating pattern, checked also against literal bits.
      din8 = 8'b0101_0101;
      pat  = 8'b0101_0101;
      for (int k = 1; k <= 9; k++) begin
         step("seq");
         chk("seq_lit", 32'(dout8), 32'(pat[(8 - k + 8) % 8]));
      end

      // Reload with datain changing mid-frame.
      @(negedge clk);
      pulse_reset("rl_rst");
      din8 = 8'hA5;
      pat  = 8'hA5;
      for (int k = 1; k <= 16; k++) begin
         if (k == 4) begin
            din8 = 8'h3C;
         end
         if (k == 9) pat = 8'h3C;
         step("reload");
         chk("reload_lit", 32'(dout8), 32'(pat[(16 - k) % 8]));
      end

      // Reset in the middle of a frame.
      pulse_reset("mid_pre");
      din8 = 8'hC3;
      for (int k = 1; k <= 4; k++) step("mid");
      pulse_reset("mid");
      din8 = 8'h9E;
      step("mid_reload");
      chk("mid_msb", 32'(dout8), 32'd1);

      // Minimum width: 1,0 repeating.
      pulse_reset("min_rst");
      din2 = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         step("min");
         chk("min_lit", 32'(dout2), 32'(k % 2));
      end

      // Random words, random datain changes, occasional resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0)
            din8 = 8'($urandom);
         if ($urandom_range(0, 1) == 0)
            din2 = 2'($urandom);
         if ($urandom_range(0, 49) == 0)
            pulse_reset("rnd_rst");
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
